z_core_muldiv: RTL

- Iterative RV32M multiply/divide unit in the Z-Core execute stage, alongside the ALU.
- Driven by the same funct3 field the ALU control decodes; selected when opcode is R-type (0110011) and funct7 is 0000001.
- Uses one radix-2 iteration per clock with a start/busy/done handshake, so the core stalls while it is busy.

---
 rtl/z_core_muldiv.sv | 111 +++++++++++
 1 files changed

// File: rtl/z_core_muldiv.sv
// z_core_muldiv: iterative radix-2 RV32M multiply/divide unit with start/busy/done handshake
module z_core_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      alu_funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   m_q, m_d, res_q, res_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic              is_mul, s1, s2, a_neg, b_neg, ge;
  logic [XLEN-1:0]   mag_a, mag_b, q, r, fin_res;
  logic [XLEN:0]     msum, dt;
  logic [2*XLEN-1:0] mul_step, div_step, prod;
  // operand decode, one shift-add / restoring-subtract step, and final sign correction
  always_comb begin
    is_mul   = ~alu_funct3[2];
    s1       = is_mul ? (alu_funct3 != 3'b011) : ~alu_funct3[0];
    s2       = is_mul ? (alu_funct3[1] == 1'b0) : ~alu_funct3[0];
    a_neg    = s1 & rs1[XLEN-1];
    b_neg    = s2 & rs2[XLEN-1];
    mag_a    = a_neg ? -rs1 : rs1;
    mag_b    = b_neg ? -rs2 : rs2;
    msum     = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_step = {msum, p_q[XLEN-1:1]};
    dt       = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    ge       = dt >= {1'b0, m_q};
    div_step = {ge ? dt[XLEN-1:0] - m_q : dt[XLEN-1:0], p_q[XLEN-2:0], ge};
    prod     = neg_q ? -p_q : p_q;
    q        = dz_q ? '1 : (neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0]);
    r        = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    fin_res  = op_q[2] ? (op_q[1] ? r : q) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  // next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    p_d     = p_q;
    m_d     = m_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        cnt_d   = '0;
        op_d    = alu_funct3;
        p_d     = is_mul ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, mag_a};
        m_d     = is_mul ? mag_a : mag_b;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = ~is_mul & (rs2 == '0);
      end
      CALC: begin
        p_d     = op_q[2] ? div_step : mul_step;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(XLEN-1)) ? FIN : CALC;
      end
      FIN: begin
        res_d   = fin_res;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      p_q     <= p_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign result = res_q;
endmodule
